// File: rtl/stream_packer.sv
// Packs PACK_RATIO narrow stream beats into one wide word with a lane keep mask.
// The wide word sits in a registered valid/ready output stage.
module stream_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            input_data,
    input  logic                             input_valid,
    input  logic                             input_last,
    output logic                             input_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_keep,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int OW = DATA_WIDTH * PACK_RATIO;
    localparam int CW = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(PACK_RATIO - 1);

    logic [CW-1:0]         count_q, count_d;
    logic [OW-1:0]         acc_q, acc_d;
    logic [PACK_RATIO-1:0] keep_q, keep_d;
    logic [OW-1:0]         out_data_q, out_data_d;
    logic [PACK_RATIO-1:0] out_keep_q, out_keep_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;

    logic                  in_accept;
    logic                  out_accept;
    logic                  completing;
    logic [OW-1:0]         acc_next;
    logic [PACK_RATIO-1:0] keep_next;

    // Ready depends only on the output register and out_ready.
    assign input_ready = !out_valid_q || out_ready;
    assign in_accept   = input_valid && input_ready;
    assign out_accept  = out_valid_q && out_ready;
    assign completing  = in_accept && ((count_q == LAST_IDX) || input_last);

    always_comb begin
        acc_next  = acc_q;
        keep_next = keep_q;
        for (int i = 0; i < PACK_RATIO; i++) begin
            if (count_q == CW'(i)) begin
                acc_next[i*DATA_WIDTH +: DATA_WIDTH] = input_data;
                keep_next[i] = 1'b1;
            end
        end
    end

    // Lanes not yet written stay zero because the accumulator clears per word.
    always_comb begin
        count_d     = count_q;
        acc_d       = acc_q;
        keep_d      = keep_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (out_accept) begin
            out_valid_d = 1'b0;
        end
        if (completing) begin
            out_data_d  = acc_next;
            out_keep_d  = keep_next;
            out_last_d  = input_last;
            out_valid_d = 1'b1;
            count_d     = '0;
            acc_d       = '0;
            keep_d      = '0;
        end else if (in_accept) begin
            count_d = count_q + CW'(1);
            acc_d   = acc_next;
            keep_d  = keep_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            acc_q       <= '0;
            keep_q      <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            acc_q       <= acc_d;
            keep_q      <= keep_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer: a packing model pushes expected words,
// a monitor pops and compares them on every output handshake.
module tb_stream_packer;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic        clk;
    logic        reset;
    logic [7:0]  input_data;
    logic        input_valid;
    logic        input_last;
    logic        input_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int n_vec;
    int n_err;
    word_t sb[$];

    logic [31:0] m_word;
    logic [3:0]  m_keep;
    int          m_cnt;

    logic t4_on;
    int   t4_stalls;
    int   t4_ov;

    stream_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
        .clk(clk),
        .reset(reset),
        .input_data(input_data),
        .input_valid(input_valid),
        .input_last(input_last),
        .input_ready(input_ready),
        .out_data(out_data),
        .out_keep(out_keep),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_word = '0;
        m_keep = '0;
        m_cnt  = 0;
    endtask

    task automatic model_beat(input logic [7:0] d, input logic last);
        word_t w;
        m_word[m_cnt*8 +: 8] = d;
        m_keep[m_cnt] = 1'b1;
        if (m_cnt == 3 || last) begin
            w.d = m_word;
            w.k = m_keep;
            w.l = last;
            sb.push_back(w);
            model_clear();
        end else begin
            m_cnt++;
        end
    endtask

    // Entered and left at posedge+1; returns right after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        input_data  = d;
        input_last  = last;
        input_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (input_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            check("accept_timeout", 64'(input_ready), 64'd1);
        end else begin
            @(posedge clk); #1;
            model_beat(d, last);
        end
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        word_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("word_data", 64'(out_data), 64'(e.d));
                check("word_keep", 64'(out_keep), 64'(e.k));
                check("word_last", 64'(out_last), 64'(e.l));
            end
        end
        if (t4_on && input_valid && !input_ready) t4_stalls++;
        if (t4_on && out_valid) t4_ov++;
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        t4_on       = 1'b0;
        t4_stalls   = 0;
        t4_ov       = 0;
        reset       = 1'b1;
        input_data  = '0;
        input_valid = 1'b0;
        input_last  = 1'b0;
        out_ready   = 1'b1;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_keep",  64'(out_keep),  64'd0);
        check("rst_last",  64'(out_last),  64'd0);
        check("rst_ready", 64'(input_ready), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // T1 full word
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        check("t1_no_early_valid", 64'(out_valid), 64'd0);
        send_beat(8'h44, 1'b0);
        check("t1_valid_rise", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'h44332211);
        @(posedge clk); #1;
        check("t1_valid_fall", 64'(out_valid), 64'd0);

        // T2 early close, next beat in lane 0
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        check("t2_data", 64'(out_data), 64'h0000BBAA);
        check("t2_keep", 64'(out_keep), 64'h3);
        send_beat(8'hCC, 1'b1);
        check("t2_lane0", 64'(out_data), 64'h000000CC);
        @(posedge clk); #1;

        // T3 stall with out_ready low
        out_ready = 1'b0;
        send_beat(8'hA1, 1'b0);
        send_beat(8'hA2, 1'b0);
        send_beat(8'hA3, 1'b0);
        send_beat(8'hA4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            input_valid = 1'b1;
            input_data  = 8'hEE;
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_ready_low", 64'(input_ready), 64'd0);
            check("t3_data_stable", 64'(out_data), 64'hA4A3A2A1);
            @(posedge clk); #1;
        end
        input_valid = 1'b0;
        out_ready   = 1'b1;
        #1;
        check("t3_ready_comb", 64'(input_ready), 64'd1);
        @(posedge clk); #1;
        check("t3_accepted_once", 64'(out_valid), 64'd0);

        // T4 back-to-back
        t4_on = 1'b1;
        for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
        @(posedge clk); #1;
        t4_on = 1'b0;
        check("t4_ready_stalls", 64'(t4_stalls), 64'd0);
        check("t4_valid_cycles", 64'(t4_ov), 64'd2);

        // T5 reset mid-word
        send_beat(8'h5A, 1'b0);
        send_beat(8'h5B, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("t5_async_clear", 64'(out_keep), 64'd0);
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b0);
        check("t5_data", 64'(out_data), 64'h04030201);
        check("t5_keep", 64'(out_keep), 64'hF);

        // T6 last on the 4th beat, then a single-beat word
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b1);
        check("t6_keep", 64'(out_keep), 64'hF);
        check("t6_last", 64'(out_last), 64'd1);
        send_beat(8'h09, 1'b1);
        check("t6_single", 64'(out_data), 64'h00000009);
        check("t6_single_keep", 64'(out_keep), 64'h1);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
